// File: rtl/prol16_mem_pkg.sv
// Shared types and helpers for the Prol16 memory responder.
//   mem_state_t    : responder FSM states
//   mem_op_t       : captured bus operation
//   wait_cnt_width : width of the wait-state down-counter for a given wait count
package prol16_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  // The counter must be at least one bit wide, even with zero wait states.
  function automatic int wait_cnt_width(input int wait_states);
    int w;
    w = $clog2(wait_states + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/prol16_mem_array.sv
// Word array with one CPU port and an independent preload port.
//   clk       : clock, rising edge
//   cpu_addr  : CPU address (combinational read, write on cpu_we)
//   cpu_we    : CPU write strobe
//   cpu_wdata : CPU write data
//   cpu_rdata : read data, 0 for out-of-range addresses
//   load_en   : preload write strobe
//   load_addr : preload address
//   load_data : preload data
// Writes to addresses >= gDepth are dropped. On a same-edge collision the
// CPU write wins. Reads are combinational, so a register sampling
// cpu_rdata on an edge that also writes sees the old contents.
module prol16_mem_array
  import prol16_mem_pkg::*;
#(
  parameter int gDataWidth = 16,
  parameter int gAddrWidth = 16,
  parameter int gDepth     = 4096
) (
  input  logic                  clk,
  input  logic [gAddrWidth-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [gDataWidth-1:0] cpu_wdata,
  output logic [gDataWidth-1:0] cpu_rdata,
  input  logic                  load_en,
  input  logic [gAddrWidth-1:0] load_addr,
  input  logic [gDataWidth-1:0] load_data
);

  localparam int IdxW = (gDepth > 1) ? $clog2(gDepth) : 1;
  localparam logic [gAddrWidth:0] DepthL = (gAddrWidth + 1)'(gDepth);

  logic [gDataWidth-1:0] mem [gDepth];

  function automatic logic in_range(input logic [gAddrWidth-1:0] a);
    return {1'b0, a} < DepthL;
  endfunction

  assign cpu_rdata = in_range(cpu_addr) ? mem[cpu_addr[IdxW-1:0]] : '0;

  // CPU write is scheduled last so it overrides a preload to the same word.
  always_ff @(posedge clk) begin
    if (load_en && in_range(load_addr))
      mem[load_addr[IdxW-1:0]] <= load_data;
    if (cpu_we && in_range(cpu_addr))
      mem[cpu_addr[IdxW-1:0]] <= cpu_wdata;
  end

endmodule

// File: rtl/prol16_mem_responder.sv
// Prol16 SRAM-style memory slave with wait states and a ready pulse.
//   clk, rst            : clock (rising edge), async active-high reset
//   mem_addr_i          : CPU address, bits above gAddrWidth ignored
//   mem_data_i          : CPU write data
//   mem_data_o          : read data, updated on entry to ACK, held otherwise
//   mem_ce_ni/oe_ni/we_ni : active-low chip/output/write enables
//   mem_ready_o         : one-cycle access-complete pulse
//   load_en_i/addr/data : bench preload write port
//   addr_err_o          : out-of-range access, coincident with ready
//   bus_err_o           : one-cycle pulse on protocol violation or abort
//   rd_count_o/wr_count_o : saturating completed-access counters
module prol16_mem_responder
  import prol16_mem_pkg::*;
#(
  parameter int gDataWidth  = 16,
  parameter int gAddrWidth  = 16,
  parameter int gDepth      = 4096,
  parameter int gWaitStates = 2,
  parameter int gCntWidth   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [gDataWidth-1:0] mem_addr_i,
  input  logic [gDataWidth-1:0] mem_data_i,
  output logic [gDataWidth-1:0] mem_data_o,
  input  logic                  mem_ce_ni,
  input  logic                  mem_oe_ni,
  input  logic                  mem_we_ni,
  output logic                  mem_ready_o,
  input  logic                  load_en_i,
  input  logic [gAddrWidth-1:0] load_addr_i,
  input  logic [gDataWidth-1:0] load_data_i,
  output logic                  addr_err_o,
  output logic                  bus_err_o,
  output logic [gCntWidth-1:0]  rd_count_o,
  output logic [gCntWidth-1:0]  wr_count_o
);

  localparam int WcW = wait_cnt_width(gWaitStates);
  localparam logic [WcW-1:0] WaitLoad = WcW'(gWaitStates);
  localparam logic [gAddrWidth:0] DepthL = (gAddrWidth + 1)'(gDepth);

  mem_state_t            state, state_nxt;
  logic [WcW-1:0]        wait_cnt;
  mem_op_t               op_q, acc_op;
  logic [gAddrWidth-1:0] addr_q, acc_addr;
  logic [gDataWidth-1:0] wdata_q, rdata;
  logic                  req, viol, acc_in_range, rd_enter, arr_we;

  function automatic logic [gCntWidth-1:0] sat_inc(input logic [gCntWidth-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign req  = !mem_ce_ni && (mem_oe_ni != mem_we_ni);
  assign viol = !mem_ce_ni && !mem_oe_ni && !mem_we_ni;

  // In IDLE the access being entered is the live bus request; afterwards
  // it is the captured one. This lets zero-wait reads use one array port.
  assign acc_addr     = (state == IDLE) ? mem_addr_i[gAddrWidth-1:0] : addr_q;
  assign acc_op       = (state == IDLE) ? (mem_oe_ni ? OP_WR : OP_RD) : op_q;
  assign acc_in_range = {1'b0, acc_addr} < DepthL;
  assign rd_enter     = (state_nxt == ACK) && (state != ACK) && (acc_op == OP_RD);
  assign arr_we       = (state == ACK) && (op_q == OP_WR);

  prol16_mem_array #(
    .gDataWidth(gDataWidth),
    .gAddrWidth(gAddrWidth),
    .gDepth    (gDepth)
  ) u_array (
    .clk      (clk),
    .cpu_addr (acc_addr),
    .cpu_we   (arr_we),
    .cpu_wdata(wdata_q),
    .cpu_rdata(rdata),
    .load_en  (load_en_i),
    .load_addr(load_addr_i),
    .load_data(load_data_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (gWaitStates > 0) ? WAIT : ACK;
      WAIT: begin
        if (mem_ce_ni)                   state_nxt = IDLE;
        else if (wait_cnt == WcW'(1))    state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o = (state == ACK);
    addr_err_o  = (state == ACK) && !acc_in_range;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      op_q       <= OP_RD;
      bus_err_o  <= 1'b0;
      mem_data_o <= '0;
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      bus_err_o <= ((state == IDLE) && viol) || ((state == WAIT) && mem_ce_ni);
      if ((state == IDLE) && req) begin
        wait_cnt <= WaitLoad;
        op_q     <= acc_op;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (rd_enter)
        mem_data_o <= acc_in_range ? rdata : '0;
      if (state == ACK) begin
        if (op_q == OP_RD) rd_count_o <= sat_inc(rd_count_o);
        else               wr_count_o <= sat_inc(wr_count_o);
      end
    end
  end

  // Captured request data; only meaningful while an access is in flight
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req) begin
      addr_q  <= mem_addr_i[gAddrWidth-1:0];
      wdata_q <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_prol16_mem_responder.sv
module tb_prol16_mem_responder;
  import prol16_mem_pkg::*;

  localparam int DW = 16, AW = 16, DEPTH = 4096, WS = 2, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic          ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
  logic          ready, addr_err, bus_err;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [CW-1:0] rd_count, wr_count;

  always #5 clk = ~clk;

  prol16_mem_responder #(
    .gDataWidth(DW), .gAddrWidth(AW), .gDepth(DEPTH),
    .gWaitStates(WS), .gCntWidth(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr_i(mem_addr), .mem_data_i(mem_wdata), .mem_data_o(mem_rdata),
    .mem_ce_ni(ce_n), .mem_oe_ni(oe_n), .mem_we_ni(we_n),
    .mem_ready_o(ready),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .addr_err_o(addr_err), .bus_err_o(bus_err),
    .rd_count_o(rd_count), .wr_count_o(wr_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          aerr;
    logic          is_rd;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[int];
  int n_vec = 0, n_err = 0;
  int exp_rd = 0, exp_wr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (int'(a) < DEPTH) model[int'(a)] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    model_load(a, d);
  endtask

  task automatic bus_idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
  endtask

  // One CPU access. ld_cyc < exp_lat: preload on that edge of the access;
  // ld_cyc == exp_lat: preload during the ACK cycle. hold: leave the bus
  // driven so the caller can issue the next request immediately.
  task automatic access(input bit wr, input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input int exp_lat, input int ld_cyc = -1,
                        input logic [AW-1:0] ld_a = '0, input logic [DW-1:0] ld_d = '0,
                        input bit hold = 1'b0);
    exp_t e, got_e;
    int   cyc;
    bit   got;
    e.is_rd = !wr;
    e.aerr  = (int'(a) >= DEPTH);
    e.data  = (!wr && int'(a) < DEPTH && model.exists(int'(a))) ? model[int'(a)] : '0;
    sb.push_back(e);
    mem_addr = a; mem_wdata = d; ce_n = 1'b0; oe_n = wr; we_n = !wr;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      load_en = (cyc == ld_cyc); load_addr = ld_a; load_data = ld_d;
      tick();
      if (load_en) model_load(ld_a, ld_d);
      load_en = 1'b0;
      cyc++;
      if (ready) got = 1'b1;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL access_timeout addr=%h: no ready within %0d cycles", a, cyc);
      void'(sb.pop_front());
      bus_idle();
      tick();
      return;
    end
    got_e = sb.pop_front();
    if (cyc !== exp_lat) begin
      n_err++; $display("FAIL latency addr=%h: got %0d want %0d", a, cyc, exp_lat);
    end
    n_vec++;
    if (addr_err !== got_e.aerr) begin
      n_err++; $display("FAIL addr_err addr=%h: got %b want %b", a, addr_err, got_e.aerr);
    end
    n_vec++;
    if (bus_err !== 1'b0) begin
      n_err++; $display("FAIL bus_err_at_ready addr=%h: got %b want 0", a, bus_err);
    end
    if (got_e.is_rd) begin
      n_vec++;
      if (mem_rdata !== got_e.data) begin
        n_err++; $display("FAIL read_data addr=%h: got %h want %h", a, mem_rdata, got_e.data);
      end
    end
    n_vec++;
    if (rd_count !== CW'(exp_rd) || wr_count !== CW'(exp_wr)) begin
      n_err++; $display("FAIL counters addr=%h: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                        a, rd_count, wr_count, exp_rd, exp_wr);
    end
    if (wr) begin if (exp_wr < CMAX) exp_wr++; end
    else    begin if (exp_rd < CMAX) exp_rd++; end
    if (ld_cyc == exp_lat) begin
      load_en = 1'b1; load_addr = ld_a; load_data = ld_d;
      model_load(ld_a, ld_d);
    end
    if (wr && int'(a) < DEPTH) model[int'(a)] = d;
    if (!hold) begin
      bus_idle();
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [DW-1:0] exp_data);
    n_vec++;
    if (ready !== 1'b0 || addr_err !== 1'b0 || bus_err !== 1'b0 || mem_rdata !== exp_data ||
        rd_count !== CW'(exp_rd) || wr_count !== CW'(exp_wr)) begin
      n_err++;
      $display("FAIL %s: got rdy=%b aerr=%b berr=%b data=%h rd=%0d wr=%0d want 0 0 0 %h %0d %0d",
               tag, ready, addr_err, bus_err, mem_rdata, rd_count, wr_count,
               exp_data, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    check_idle_outputs("reset_state", '0);
    rst = 1'b0;
    tick();
    check_idle_outputs("after_reset", '0);
  endtask

  task automatic test_preload_read();
    preload(16'h0010, 16'hBEEF);
    access(1'b0, 16'h0010, '0, WS + 1);
    n_vec++;
    if (rd_count !== CW'(1)) begin
      n_err++; $display("FAIL rd_count_first: got %0d want 1", rd_count);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 16'h0020, 16'h1234, WS + 1, -1, '0, '0, 1'b1);
    access(1'b0, 16'h0020, '0, WS + 2);
    n_vec++;
    if (wr_count !== CW'(1)) begin
      n_err++; $display("FAIL wr_count_first: got %0d want 1", wr_count);
    end
  endtask

  task automatic test_out_of_range();
    preload(16'h0000, 16'h5A5A);
    preload(16'h2000, 16'h0BAD);
    access(1'b0, 16'h2000, '0, WS + 1);
    access(1'b1, 16'h2000, 16'hFFFF, WS + 1);
    access(1'b0, 16'h0000, '0, WS + 1);
  endtask

  task automatic test_bus_err();
    logic [DW-1:0] last;
    last = mem_rdata;
    mem_addr = 16'h0010; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    tick();
    n_vec++;
    if (bus_err !== 1'b1 || ready !== 1'b0) begin
      n_err++; $display("FAIL viol_pulse: got berr=%b rdy=%b want 1 0", bus_err, ready);
    end
    bus_idle();
    tick();
    check_idle_outputs("viol_cleared", last);
    // Abort a write during WAIT
    preload(16'h0030, 16'h1111);
    mem_addr = 16'h0030; mem_wdata = 16'h9999; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick();
    check_idle_outputs("abort_in_wait", last);
    ce_n = 1'b1; we_n = 1'b1;
    tick();
    n_vec++;
    if (bus_err !== 1'b1 || ready !== 1'b0) begin
      n_err++; $display("FAIL abort_pulse: got berr=%b rdy=%b want 1 0", bus_err, ready);
    end
    tick();
    check_idle_outputs("abort_cleared", last);
    access(1'b0, 16'h0030, '0, WS + 1);
  endtask

  task automatic test_preload_collision();
    preload(16'h0050, 16'h1111);
    access(1'b0, 16'h0050, '0, WS + 1, WS, 16'h0050, 16'h2222);
    access(1'b0, 16'h0050, '0, WS + 1);
    access(1'b1, 16'h0040, 16'hAAAA, WS + 1, WS + 1, 16'h0040, 16'h5555);
    access(1'b0, 16'h0040, '0, WS + 1);
    preload(16'h3000, 16'h7777);
    access(1'b0, 16'h3000, '0, WS + 1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) access(1'b0, 16'h0010, '0, WS + 1);
    n_vec++;
    if (rd_count !== CW'(CMAX)) begin
      n_err++; $display("FAIL rd_count_sat: got %0d want %0d", rd_count, CMAX);
    end
  endtask

  task automatic test_reset_mid();
    preload(16'h0060, 16'h0707);
    mem_addr = 16'h0060; mem_wdata = 16'hDEAD; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick();
    rst = 1'b1;
    exp_rd = 0; exp_wr = 0;
    #1;
    check_idle_outputs("reset_mid", '0);
    bus_idle();
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("after_reset_mid", '0);
    access(1'b0, 16'h0060, '0, WS + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload_read();
    test_back_to_back();
    test_out_of_range();
    test_bus_err();
    test_preload_collision();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prol16_mem_responder.md
Name:
prol16_mem_responder

Overview:
- Synthesisable, parametrised memory slave for the Prol16 SRAM-style bus (active-low ce/oe/we). Replaces the zero-latency testbench memory.
- Adds configurable wait states with a ready handshake, range and protocol error flags, access counters, and a bench preload port.
- Sits between the CPU memory port and the verification environment.

Parameters:
gDataWidth, 16, width of data words and of mem_addr_i
gAddrWidth, 16, number of address bits decoded; must be <= gDataWidth
gDepth, 4096, number of implemented words; must be <= 2**gAddrWidth; addresses >= gDepth are out of range
gWaitStates, 2, cycles spent in WAIT before ACK (0..15)
gCntWidth, 16, width of the saturating access counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_addr_i  in  gDataWidth  CPU address; bits above gAddrWidth are ignored
mem_data_i  in  gDataWidth  CPU write data
mem_data_o  out  gDataWidth  read data returned to the CPU
mem_ce_ni  in  1  chip enable, active-low
mem_oe_ni  in  1  output enable (read), active-low
mem_we_ni  in  1  write enable, active-low
mem_ready_o  out  1  one-cycle pulse: access complete
load_en_i  in  1  bench preload write strobe
load_addr_i  in  gAddrWidth  preload address
load_data_i  in  gDataWidth  preload data
addr_err_o  out  1  pulse with ready: the access was out of range
bus_err_o  out  1  one-cycle pulse: protocol violation
rd_count_o  out  gCntWidth  completed reads, saturating
wr_count_o  out  gCntWidth  completed writes, saturating

Behaviour:
- Reset (async, while rst=1): state=IDLE; mem_data_o=0, mem_ready_o=0, addr_err_o=0, bus_err_o=0, both counters=0. Array contents are not reset.
- Request in IDLE: mem_ce_ni=0 and exactly one of oe_n/we_n is 0. On acceptance, register address, data and op; load the wait counter with gWaitStates.
- IDLE transitions: request -> WAIT if gWaitStates>0, else -> ACK.
- Protocol violation in IDLE: ce_n=0 with oe_n=0 and we_n=0 together -> bus_err_o=1 next cycle, no access, stay IDLE.
- WAIT: decrement the counter each cycle; counter==1 -> ACK.
- Abort: if ce_n rises during WAIT -> IDLE, bus_err_o=1 for one cycle, no memory update, no count.
- ACK: mem_ready_o=1 for exactly one cycle, then IDLE. The next request can be accepted in the cycle after ACK.
- Latency: request-to-ready is gWaitStates+1 cycles. Minimum access period is gWaitStates+2 cycles.
- Read: mem_data_o updates at the edge entering ACK and holds until the next completed read.
- Read out of range: mem_data_o=0, addr_err_o=1 during ACK.
- Write: the array is written at the edge leaving ACK, using the captured data.
- Write out of range: dropped, addr_err_o=1 during ACK.
- Counters: increment on in-range or out-of-range completion (in ACK) of the matching op; saturate at all-ones, no wrap.
- Preload: load_en_i writes the array at any time and in any state.
  - Same-edge collision with a CPU write to the same address: CPU write wins.
  - Preload to an address >= gDepth is ignored.
  - A preload never asserts ready or the error flags.
- Read of an address preloaded in the same cycle as ACK entry returns the old contents (read-before-write).
- Reset mid-access: the transaction is discarded and no write occurs.

Decomposition:
- Shared package prol16_mem_pkg holds:
  - state enum mem_state_t {IDLE, WAIT, ACK};
  - op enum mem_op_t {OP_RD, OP_WR};
  - localparam functions for the counter width ($clog2(gWaitStates+1)).
- Sub-module prol16_mem_array: a single-port array plus the preload port, with the stated write priority and read-before-write. The FSM, counters and error logic stay in the top level.

Test Plan:
- Preload addr 0x0010=0xBEEF; read 0x0010 with gWaitStates=2 -> ready on cycle 3, mem_data_o=0xBEEF, rd_count_o=1.
- Write 0x1234 to 0x0020, then read 0x0020 -> 0x1234; wr_count_o=1, rd_count_o=1; second request accepted the cycle after ACK.
- Read addr 0x2000 with gDepth=4096 -> mem_data_o=0, addr_err_o=1 with ready. Write to 0x2000 -> addr_err_o=1, array unchanged.
- ce_n=0, oe_n=0, we_n=0 -> bus_err_o pulse, no ready. Raise ce_n in WAIT -> bus_err_o pulse, no write, counters unchanged.
- gCntWidth=4, 17 reads -> rd_count_o=15. Assert rst during WAIT of a write -> outputs 0, target word unchanged.
